// File: rtl/tcm_dma_pkg.sv
// Shared definitions for the TCM stream DMA: FSM state encoding, lane sizing and
// the byte-address to word/lane split helpers.
package tcm_dma_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_BYTES      = DEF_DATA_WIDTH / BYTE_W;
    localparam int DEF_LANE_W     = $clog2(DEF_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WFILL,
        ST_WFLUSH,
        ST_RREQ,
        ST_RWAIT,
        ST_RDRAIN,
        ST_DONE
    } dma_state_e;

    function automatic logic [31:0] word_of(input logic [31:0] byte_addr, input int lane_w);
        return byte_addr >> lane_w;
    endfunction

    function automatic logic [31:0] lane_of(input logic [31:0] byte_addr, input int lane_w);
        return byte_addr & ((32'd1 << lane_w) - 32'd1);
    endfunction

endpackage

// File: rtl/tcm_dma_packer.sv
// Write-side word assembler: drops each accepted byte into its lane and accumulates
// the byte-enable mask until the owning FSM flushes the word.
module tcm_dma_packer
    import tcm_dma_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTES      = DEF_BYTES,
    parameter int LANE_W     = DEF_LANE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  insert_i,
    input  logic [LANE_W-1:0]     lane_i,
    input  logic [7:0]            byte_i,
    input  logic                  clear_i,
    output logic [BYTES-1:0]      mask_next_o,
    output logic [DATA_WIDTH-1:0] data_next_o
);

    logic [BYTES-1:0]      mask_q, mask_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // The _next view already holds this cycle's byte, so a flush can launch from it directly.
    always_comb begin
        mask_next_o = mask_q;
        data_next_o = data_q;
        for (int i = 0; i < BYTES; i++) begin
            if (insert_i && (lane_i == LANE_W'(i))) begin
                mask_next_o[i]                    = 1'b1;
                data_next_o[i*BYTE_W +: BYTE_W]   = byte_i;
            end
        end
        mask_d = clear_i ? '0 : mask_next_o;
        data_d = clear_i ? '0 : data_next_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= '0;
            data_q <= '0;
        end else begin
            mask_q <= mask_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/tcm_stream_dma.sv
// Byte-stream DMA initiator for one TCM SRAM port. Read mode (TCM->stream) is only
// built when TCM_DMA_READ_EN is defined; otherwise every command is a write.
module tcm_stream_dma
    import tcm_dma_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  N_ENTRIES  = 1024,
    parameter int  LEN_W      = 16,
    localparam int BYTES      = DATA_WIDTH / BYTE_W,
    localparam int LANE_W     = $clog2(BYTES),
    localparam int ADDRW      = $clog2(N_ENTRIES),
    localparam int BAW        = ADDRW + LANE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rd_i,
    input  logic [BAW-1:0]        cmd_addr_i,
    input  logic [LEN_W-1:0]      cmd_len_i,
    input  logic                  abort_i,
    output logic                  done_o,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [7:0]            s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [7:0]            m_data_o,
    output logic                  tcm_en_o,
    output logic                  tcm_we_o,
    output logic [BYTES-1:0]      tcm_be_o,
    output logic [ADDRW-1:0]      tcm_addr_o,
    output logic [DATA_WIDTH-1:0] tcm_data_o,
    input  logic [DATA_WIDTH-1:0] tcm_data_i,
    input  logic                  tcm_ready_i
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    dma_state_e            state_q, state_d;
    logic [BAW-1:0]        addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [LANE_W-1:0]     lane;
    logic [ADDRW-1:0]      word_cur;
    logic                  pack_insert;
    logic                  pack_clear;
    logic [BYTES-1:0]      pack_mask_next;
    logic [DATA_WIDTH-1:0] pack_data_next;

    logic                  tcm_en_q, tcm_en_d;
    logic                  tcm_we_q, tcm_we_d;
    logic [BYTES-1:0]      tcm_be_q, tcm_be_d;
    logic [ADDRW-1:0]      tcm_addr_q, tcm_addr_d;
    logic [DATA_WIDTH-1:0] tcm_data_q, tcm_data_d;

    assign lane     = LANE_W'(lane_of(32'(addr_q), LANE_W));
    assign word_cur = ADDRW'(word_of(32'(addr_q), LANE_W));

    // Anything left in the packer outside a fill, or on abort, is a discarded partial word.
    assign pack_clear = abort_i || (state_q != ST_WFILL);

    tcm_dma_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES      (BYTES),
        .LANE_W     (LANE_W)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .insert_i    (pack_insert),
        .lane_i      (lane),
        .byte_i      (s_data_i),
        .clear_i     (pack_clear),
        .mask_next_o (pack_mask_next),
        .data_next_o (pack_data_next)
    );

`ifdef TCM_DMA_READ_EN
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    assign m_data_o = rdata_q[{lane, 3'b000} +: BYTE_W];
`else
    logic unused_read_path;

    assign unused_read_path = ^{cmd_rd_i, m_ready_i, tcm_ready_i, tcm_data_i};
    assign m_data_o         = '0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cmd_ready_o = 1'b0;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        done_o      = 1'b0;
        pack_insert = 1'b0;
`ifdef TCM_DMA_READ_EN
        rdata_d     = rdata_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = !abort_i;
                if (cmd_valid_i && !abort_i) begin
                    addr_d = cmd_addr_i;
                    rem_d  = cmd_len_i;
                    if (cmd_len_i == '0) begin
                        state_d = ST_DONE;
`ifdef TCM_DMA_READ_EN
                    end else if (cmd_rd_i) begin
                        state_d = ST_RREQ;
`endif
                    end else begin
                        state_d = ST_WFILL;
                    end
                end
            end
            ST_WFILL: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    pack_insert = 1'b1;
                    addr_d      = addr_q + BAW'(1);
                    rem_d       = rem_q - LEN_W'(1);
                    if ((lane == LAST_LANE) || (rem_q == LEN_W'(1))) begin
                        state_d = ST_WFLUSH;
                    end
                end
            end
            ST_WFLUSH: begin
                state_d = (rem_q == '0) ? ST_DONE : ST_WFILL;
            end
`ifdef TCM_DMA_READ_EN
            ST_RREQ: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (tcm_ready_i) begin
                    rdata_d = tcm_data_i;
                    state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    addr_d = addr_q + BAW'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (lane == LAST_LANE) begin
                        state_d = ST_RREQ;
                    end
                end
            end
`endif
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    // SRAM port outputs are registered, so they are decided from the state being entered.
    always_comb begin
        tcm_en_d   = 1'b0;
        tcm_we_d   = 1'b0;
        tcm_be_d   = '0;
        tcm_addr_d = '0;
        tcm_data_d = '0;
        if (state_d == ST_WFLUSH) begin
            tcm_en_d   = 1'b1;
            tcm_we_d   = 1'b1;
            tcm_be_d   = pack_mask_next;
            tcm_addr_d = word_cur;
            tcm_data_d = pack_data_next;
        end
`ifdef TCM_DMA_READ_EN
        else if (state_d == ST_RREQ) begin
            tcm_en_d   = 1'b1;
            tcm_addr_d = ADDRW'(word_of(32'(addr_d), LANE_W));
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            tcm_en_q   <= 1'b0;
            tcm_we_q   <= 1'b0;
            tcm_be_q   <= '0;
            tcm_addr_q <= '0;
            tcm_data_q <= '0;
`ifdef TCM_DMA_READ_EN
            rdata_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tcm_en_q   <= tcm_en_d;
            tcm_we_q   <= tcm_we_d;
            tcm_be_q   <= tcm_be_d;
            tcm_addr_q <= tcm_addr_d;
            tcm_data_q <= tcm_data_d;
`ifdef TCM_DMA_READ_EN
            rdata_q    <= rdata_d;
`endif
        end
    end

    assign tcm_en_o   = tcm_en_q;
    assign tcm_we_o   = tcm_we_q;
    assign tcm_be_o   = tcm_be_q;
    assign tcm_addr_o = tcm_addr_q;
    assign tcm_data_o = tcm_data_q;

endmodule
